// File: rtl/uart_mmio_peripheral.sv
// uart_mmio_peripheral: memory-mapped 8N1 UART responder with TX FIFO and one-byte RX holding register
// Ports: clk/reset (sync, active-high); WE/RE/ADDR/WD core bus strobes, address and store data;
// RD/hit combinational read data and window decode; rx async serial in; tx registered serial out.
module uart_mmio_peripheral #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
   parameter int          CLKS_PER_BIT = 868,
   parameter int          TX_DEPTH     = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  WE,
   input  logic        RE,
   input  logic [31:0] ADDR,
   input  logic [31:0] WD,
   output logic [31:0] RD,
   output logic        hit,
   input  logic        rx,
   output logic        tx
);
   localparam int AW = $clog2(TX_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
   logic [7:0]    r_mem [TX_DEPTH];
   logic [AW:0]   r_wp, r_rp;
   state_t        r_tx_st, r_rx_st;
   logic [CW-1:0] r_tx_cnt, r_rx_cnt;
   logic [2:0]    r_tx_bit, r_rx_bit;
   logic [7:0]    r_tx_sh, r_rx_sh, r_rx_data;
   logic          r_rx_s1, r_rx_s2, r_rx_valid, r_rx_ovr, r_tx_ovf, r_rx_ferr;
   logic          w_tx_wr, w_st_wr, w_rx_rd, w_empty, w_full, w_pop, w_push, w_busy;
   logic          w_tx_tick, w_rx_tick, w_rx_half, w_stop, w_ok;
   logic [6:0]    w_status;
   logic          w_unused;
   assign w_unused  = &{1'b0, WD[31:8], ADDR[1:0]};
   assign hit       = ADDR[31:4] == BASE_ADDR[31:4];
   assign w_tx_wr   = hit & (WE != 2'b00) & (ADDR[3:2] == 2'd0);
   assign w_st_wr   = hit & (WE != 2'b00) & (ADDR[3:2] == 2'd2);
   assign w_rx_rd   = hit & RE & (ADDR[3:2] == 2'd1);
   assign w_empty   = r_wp == r_rp;
   assign w_full    = (r_wp ^ r_rp) == {1'b1, {AW{1'b0}}};
   assign w_tx_tick = r_tx_cnt == C_LAST;
   assign w_rx_tick = r_rx_cnt == C_LAST;
   assign w_rx_half = r_rx_cnt == C_HALF;
   // the serializer takes a byte either from idle or straight out of a finished stop bit
   assign w_pop     = !w_empty & ((r_tx_st == S_IDLE) | ((r_tx_st == S_STOP) & w_tx_tick));
   // a full FIFO still accepts a push on a pop edge: the freed slot is the one written
   assign w_push    = w_tx_wr & (!w_full | w_pop);
   assign w_busy    = !w_empty | (r_tx_st != S_IDLE);
   assign w_stop    = (r_rx_st == S_STOP) & w_rx_tick;
   assign w_ok      = w_stop & r_rx_s2;
   assign w_status  = {r_rx_ferr, r_tx_ovf, r_rx_ovr, r_rx_valid, w_busy, w_empty, w_full};
   assign RD        = !hit ? 32'd0 : (ADDR[3:2] == 2'd1) ? {24'd0, r_rx_data} :
                      (ADDR[3:2] == 2'd2) ? {25'd0, w_status} : 32'd0;
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wp[AW-1:0]] <= WD[7:0];
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         r_wp <= w_push ? r_wp + 1'b1 : r_wp;
         r_rp <= w_pop ? r_rp + 1'b1 : r_rp;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tx_st  <= S_IDLE;
         r_tx_cnt <= '0;
         r_tx_bit <= '0;
         r_tx_sh  <= '0;
         tx       <= 1'b1;
      end else begin
         r_tx_cnt <= (r_tx_st == S_IDLE || w_tx_tick) ? '0 : r_tx_cnt + 1'b1;
         if (w_pop) begin
            r_tx_sh <= r_mem[r_rp[AW-1:0]];
            tx      <= 1'b0;
            r_tx_st <= S_START;
         end else if (w_tx_tick) begin
            case (r_tx_st)
               S_START: begin
                  tx       <= r_tx_sh[0];
                  r_tx_sh  <= r_tx_sh >> 1;
                  r_tx_bit <= '0;
                  r_tx_st  <= S_DATA;
               end
               S_DATA: begin
                  tx       <= (r_tx_bit == 3'd7) ? 1'b1 : r_tx_sh[0];
                  r_tx_sh  <= r_tx_sh >> 1;
                  r_tx_bit <= r_tx_bit + 1'b1;
                  r_tx_st  <= (r_tx_bit == 3'd7) ? S_STOP : S_DATA;
               end
               S_STOP:  r_tx_st <= S_IDLE;
               default: r_tx_st <= S_IDLE;
            endcase
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_s1  <= 1'b1;
         r_rx_s2  <= 1'b1;
         r_rx_st  <= S_IDLE;
         r_rx_cnt <= '0;
         r_rx_bit <= '0;
         r_rx_sh  <= '0;
      end else begin
         r_rx_s1  <= rx;
         r_rx_s2  <= r_rx_s1;
         r_rx_cnt <= (r_rx_st == S_IDLE || w_rx_tick || (r_rx_st == S_START && w_rx_half)) ? '0 : r_rx_cnt + 1'b1;
         case (r_rx_st)
            S_IDLE:  r_rx_st <= r_rx_s2 ? S_IDLE : S_START;
            S_START: if (w_rx_half) r_rx_st <= r_rx_s2 ? S_IDLE : S_DATA;
            S_DATA: if (w_rx_tick) begin
               r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
               r_rx_bit <= r_rx_bit + 1'b1;
               r_rx_st  <= (r_rx_bit == 3'd7) ? S_STOP : S_DATA;
            end
            S_STOP:  if (w_rx_tick) r_rx_st <= S_IDLE;
            default: r_rx_st <= S_IDLE;
         endcase
      end
   end
   // a new byte lands when the holder is empty or being read out this very edge
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_rx_ovr   <= 1'b0;
         r_tx_ovf   <= 1'b0;
         r_rx_ferr  <= 1'b0;
      end else begin
         r_rx_data  <= (w_ok & (!r_rx_valid | w_rx_rd)) ? r_rx_sh : r_rx_data;
         r_rx_valid <= w_ok | (r_rx_valid & !w_rx_rd);
         r_rx_ovr   <= (r_rx_ovr & !(w_st_wr & WD[4])) | (w_ok & r_rx_valid & !w_rx_rd);
         r_tx_ovf   <= (r_tx_ovf & !(w_st_wr & WD[5])) | (w_tx_wr & w_full & !w_pop);
         r_rx_ferr  <= (r_rx_ferr & !(w_st_wr & WD[6])) | (w_stop & !r_rx_s2);
      end
   end
endmodule

// File: tb/tb_uart_mmio_peripheral.sv
// tb_uart_mmio_peripheral: directed plus randomized bench against a frame-level UART model
module tb_uart_mmio_peripheral;
   localparam logic [31:0] BASE = 32'h0000_0400;
   localparam int C = 4;
   logic        clk = 1'b0;
   logic        reset, RE, hit, rx, tx;
   logic [1:0]  WE;
   logic [31:0] ADDR, WD, RD;
   always #5 clk = ~clk;
   uart_mmio_peripheral #(.BASE_ADDR(BASE), .CLKS_PER_BIT(C), .TX_DEPTH(16)) dut (
      .clk(clk), .reset(reset), .WE(WE), .RE(RE), .ADDR(ADDR), .WD(WD),
      .RD(RD), .hit(hit), .rx(rx), .tx(tx));
   typedef struct {int at; logic [7:0] b; bit ok;} rx_ev_t;
   int         total = 0, bad = 0, cyc = 0, p_last = 0;
   bit         exp_tx [0:16383];
   logic [7:0] mq[$];
   bit         q_rx[$];
   rx_ev_t     ev[$];
   bit         popped, m_valid, m_ovr, m_ovf, m_ferr;
   logic [7:0] m_rx;
   function automatic logic [31:0] mstat();
      bit busy;
      busy = mq.size() > 0 || (popped && cyc <= p_last + 40);
      return {25'd0, m_ferr, m_ovf, m_ovr, m_valid, busy, mq.size() == 0, mq.size() == 16};
   endfunction
   function automatic logic [31:0] mrd(input logic [31:0] a);
      if (a[31:4] != BASE[31:4]) return 32'd0;
      return (a[3:2] == 2'd1) ? {24'd0, m_rx} : (a[3:2] == 2'd2) ? mstat() : 32'd0;
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
      end
   endtask
   task automatic model_reset();
      mq.delete();
      ev.delete();
      popped = 0;
      {m_valid, m_ovr, m_ovf, m_ferr} = '0;
      m_rx = '0;
      for (int k = cyc + 1; k <= cyc + 41; k++) exp_tx[k] = 1'b1;
   endtask
   task automatic step(input bit r, input logic [1:0] w, input bit re, input logic [31:0] a, input logic [31:0] d);
      bit h, full0, pop, rdx;
      rx_ev_t e;
      @(negedge clk);
      reset = 0; WE = 0; RE = 0; ADDR = BASE + 8; #1;
      chk("status", RD, mstat());
      chk("tx", {31'd0, tx}, {31'd0, exp_tx[cyc]});
      ADDR = BASE + 4; #1;
      chk("rxdata", RD, {24'd0, m_rx});
      if (r) q_rx.delete();
      rx = q_rx.size() > 0 ? q_rx.pop_front() : 1'b1;
      reset = r; WE = w; RE = re; ADDR = a; WD = d; #1;
      h = a[31:4] == BASE[31:4];
      chk("hit", {31'd0, hit}, {31'd0, h});
      chk("rd", RD, mrd(a));
      if (r) model_reset();
      else begin
         full0 = mq.size() == 16;
         pop = mq.size() > 0 && (!popped || cyc >= p_last + 40);
         if (pop) begin
            logic [7:0] pb;
            pb = mq.pop_front();
            for (int k = 0; k < 40; k++) exp_tx[cyc + 1 + k] = (k < 4) ? 1'b0 : (k >= 36) ? 1'b1 : pb[(k - 4) / 4];
            popped = 1;
            p_last = cyc;
         end
         if (h && w != 0 && a[3:2] == 2'd0) begin
            if (!full0 || pop) mq.push_back(d[7:0]);
            else m_ovf = 1;
         end
         if (h && w != 0 && a[3:2] == 2'd2) begin
            if (d[4]) m_ovr = 0;
            if (d[5]) m_ovf = 0;
            if (d[6]) m_ferr = 0;
         end
         rdx = h && re && a[3:2] == 2'd1;
         if (rdx) m_valid = 0;
         if (ev.size() > 0 && ev[0].at == cyc) begin
            e = ev.pop_front();
            if (!e.ok) m_ferr = 1;
            else if (!m_valid && (rdx || !m_valid)) begin
               m_rx = e.b;
               m_valid = 1;
            end else m_ovr = 1;
         end
      end
      cyc++;
   endtask
   task automatic idle(input int n);
      repeat (n) step(0, 2'b00, 0, 32'h0, 32'h0);
   endtask
   task automatic till(input int t);
      while (cyc < t) idle(1);
   endtask
   task automatic send_rx(input logic [7:0] b, input bit ok);
      ev.push_back('{cyc + q_rx.size() + 40, b, ok});
      for (int k = 0; k < 40; k++) q_rx.push_back(k < 4 ? 1'b0 : k < 36 ? b[(k - 4) / 4] : ok);
      if (!ok) repeat (8) q_rx.push_back(1'b1);
   endtask
   initial begin
      int r;
      reset = 1; WE = 0; RE = 0; ADDR = 0; WD = 0; rx = 1;
      for (int k = 0; k < 16384; k++) exp_tx[k] = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      idle(2);
      step(0, 2'b00, 1, BASE + 12, 0);
      step(0, 2'b00, 0, BASE, 0);
      step(0, 2'b01, 0, BASE + 12, 32'hFF);
      step(0, 2'b11, 0, BASE + 4, 32'h55);
      step(0, 2'b10, 0, BASE + 32'h10, 32'h77);
      step(0, 2'b01, 0, BASE, 32'hA5);
      idle(45);
      step(0, 2'b01, 0, BASE, $urandom);
      for (int i = 0; i <= 16; i++) step(0, 2'b01, 0, BASE, i);
      till(p_last + 40);
      step(0, 2'b11, 0, BASE, 32'h5A);
      step(0, 2'b01, 0, BASE + 8, 32'h20);
      idle(720);
      send_rx(8'h3C, 1);
      idle(42);
      step(0, 2'b00, 0, BASE + 4, 0);
      step(0, 2'b00, 1, BASE + 4, 0);
      send_rx(8'h11, 1);
      send_rx(8'h22, 1);
      idle(82);
      step(0, 2'b01, 0, BASE + 8, 32'h10);
      send_rx(8'h33, 1);
      till(ev[0].at);
      step(0, 2'b00, 1, BASE + 4, 0);
      idle(2);
      step(0, 2'b00, 1, BASE + 4, 0);
      q_rx.push_back(1'b0);
      repeat (8) q_rx.push_back(1'b1);
      idle(12);
      send_rx(8'($urandom), 0);
      idle(50);
      step(0, 2'b01, 0, BASE + 8, 32'h40);
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 99);
         if (q_rx.size() == 0 && $urandom_range(0, 59) == 0) send_rx(8'($urandom), $urandom_range(0, 7) != 0);
         if (r < 4) step(0, 2'($urandom_range(1, 3)), 0, BASE, $urandom);
         else if (r < 8) step(0, 2'b00, 1, BASE + 4, 0);
         else if (r < 10) step(0, 2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), BASE + 32'h20 + 32'($urandom_range(0, 3) << 2), $urandom);
         else idle(1);
      end
      step(0, 2'b01, 0, BASE, $urandom);
      send_rx(8'($urandom), 1);
      idle(20);
      step(1, 2'b00, 0, 32'h0, 0);
      idle(5);
      step(0, 2'b01, 0, BASE, $urandom);
      idle(45);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_mmio_peripheral.md
# uart_mmio_peripheral

Memory-mapped UART peripheral that sits on the single-cycle core's data-memory bus as a responder. It is the target side of the core's load/store accesses, alongside data memory. Core stores enqueue bytes into a TX FIFO that an 8N1 serializer drains onto `tx`. An 8N1 receiver deserializes `rx` into a one-byte holding register that core loads read out.

## Interface
- `BASE_ADDR`, 32'h0000_0400: base of the 16-byte register window; bits [3:0] must be zero.
- `CLKS_PER_BIT`, 868: clock cycles per UART bit; must be ≥ 4.
- `TX_DEPTH`, 16: TX FIFO entries; power of two.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `WE`  in  2  store strobe from core. 2'b00 means no write; any nonzero value is a write, and only `WD[7:0]` is used.
- `RE`  in  1  load strobe from core. Qualifies read side effects only.
- `ADDR`  in  32  byte address from core ALU.
- `WD`  in  32  store data.
- `RD`  out  32  read data. Combinational from `ADDR`; 0 when not hit.
- `hit`  out  1  combinational; 1 when `ADDR[31:4] == BASE_ADDR[31:4]`.
- `rx`  in  1  serial input, asynchronous.
- `tx`  out  1  serial output, registered; idles high.

## Operation
Register map, decoded by `ADDR[3:2]` when `hit`:
- **0x0 TXDATA (W)**
  - Write pushes `WD[7:0]` into the FIFO.
  - If the FIFO is full, the byte is dropped and `tx_ovf` is set.
  - Exception: a push in the same cycle the serializer pops is accepted.
  - Reads return 0.
- **0x4 RXDATA (R)**
  - `RD = {24'b0, rx_data}`.
  - `hit & RE` at this offset clears `rx_valid` at the edge.
  - Writes are ignored.
- **0x8 STATUS (R/W1C)**
  - Bit 0 `tx_full`, bit 1 `tx_empty`, bit 2 `tx_busy` (FIFO nonempty or serializer active), bit 3 `rx_valid`, bit 4 `rx_ovr`, bit 5 `tx_ovf`, bit 6 `rx_ferr`; upper bits read 0.
  - A write with `WD[4]`, `WD[5]` or `WD[6]` set clears that flag. Other bits are read-only.
- **0xC**: reserved; reads 0, writes ignored.

Accesses with `hit = 0` have no effect.

TX serializer states: IDLE, START, DATA, STOP.
- **IDLE**: on any edge where the FIFO is nonempty, pop the head into the shift register, drive `tx = 0`, and go to START.
- **START**: hold 0 for `CLKS_PER_BIT` cycles.
- **DATA**: 8 bits, LSB first, `CLKS_PER_BIT` cycles each.
- **STOP**: `tx = 1` for `CLKS_PER_BIT` cycles. Then pop the next byte directly into START if the FIFO is nonempty, else go to IDLE. There is no idle gap between back-to-back frames.

RX states: IDLE, START, DATA, STOP.
- `rx` passes through a 2-flop synchronizer; all references below are to the synchronized value.
- **IDLE**: a synchronized low moves to START.
- **START**: at `CLKS_PER_BIT/2` cycles, re-sample.
  - If high, it was a false start: return to IDLE.
  - Otherwise go to DATA.
- **DATA**: sample every `CLKS_PER_BIT` cycles, 8 bits LSB first.
- **STOP**: sample once after `CLKS_PER_BIT` cycles.
  - Stop bit 0: set `rx_ferr`, discard the byte, and go to IDLE.
  - Stop bit 1 with `rx_valid = 0`: load `rx_data` and set `rx_valid`.
  - Stop bit 1 with `rx_valid = 1` and no RXDATA read this cycle: drop the new byte, keep the old one, set `rx_ovr`.
  - Stop bit 1 on the same cycle as an RXDATA read: load the new byte, keep `rx_valid = 1`, no overrun.
- Then IDLE. A frame may start on the cycle after leaving STOP.

Reset, including mid-frame:
- FIFO empty, both FSMs to IDLE.
- `tx = 1`.
- `rx_data = 0`.
- All flags 0.

## Timing
- A TXDATA write at edge k into an empty FIFO with an IDLE serializer: `tx` falls after edge k+1, and the frame lasts exactly `10*CLKS_PER_BIT` cycles.
- `tx_empty` drops after edge k and returns to 1 after edge k+1 (the pop). `tx_busy` stays 1 until the last stop-bit cycle ends.
- RX latency: `rx_valid` rises 2 synchronizer cycles plus about `9.5*CLKS_PER_BIT` after the `rx` start edge.
- `RD` and `hit` are purely combinational, with zero-cycle read latency to suit the single-cycle core. Side effects apply at the edge ending the access.
- FIFO pointers are `log2(TX_DEPTH)+1` bits and wrap naturally. Full means the pointers are equal except the MSB.

## Test plan
- Use `CLKS_PER_BIT = 4`. Write TXDATA = 0xA5 → `tx` = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles. `tx_empty` = 1 after one cycle; `tx_busy` = 0 after 40 cycles.
- Write 17 bytes 0x00..0x10 back-to-back while the serializer is busy → 0x00..0x0F transmitted in order with no gaps. The 17th byte is dropped, or accepted if it lands on a pop cycle. If dropped, STATUS bit 5 = 1; writing STATUS = 0x20 clears it.
- Drive a valid `rx` frame of 0x3C → `rx_valid` = 1 and RXDATA reads 0x3C. A load with `RE = 1` clears `rx_valid`; a read with `RE = 0` does not.
- Send 0x11 then 0x22 without reading → RXDATA = 0x11 and `rx_ovr` = 1. Send 0x33 with the RXDATA read coincident with its stop sample → RXDATA = 0x33 and no new overrun.
- Drive a 1-cycle low glitch on `rx` → no byte and no flags. Drive a frame with stop bit = 0 → `rx_ferr` = 1 and `rx_valid` unchanged.
- Assert `reset` mid-DATA on both TX and RX → the next cycle shows `tx` = 1, STATUS = 0x02, `RD` at RXDATA = 0, and the FIFO is empty.
